// File: rtl/idli_uart_tx_m.sv
// UART transmitter: nibble-serial word writes into a small FIFO, each word sent as two 8N1 frames, low byte first.
// Writes arriving while the FIFO is full are dropped at ctr==0; the serial line starts one cycle after the first commit.
module idli_uart_tx_m #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 2
) (
  input  logic       i_top_gck,
  input  logic       i_top_rst_n,
  input  logic [1:0] i_utx_ctr,
  input  logic       i_utx_wr_en,
  input  logic [3:0] i_utx_slice,
  output logic       o_utx_full,
  output logic       o_utx_busy,
  output logic       o_utx_tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state;
  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_wr_act;
  logic [15:0]   r_shift;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_byte_sel;
  logic          r_tx;

  logic          w_wr_acc;
  logic          w_wr_cap;
  logic          w_commit;
  logic          w_fifo_ne;
  logic          w_baud_end;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  assign w_wr_acc    = (i_utx_ctr == 2'd0) && i_utx_wr_en && !r_full;
  assign w_wr_cap    = w_wr_acc || (r_wr_act && (i_utx_ctr != 2'd0));
  assign w_commit    = r_wr_act && (i_utx_ctr == 2'd3);
  assign w_fifo_ne   = (r_count != '0);
  assign w_baud_end  = (r_baud == BAUD_LAST);
  // Pop from IDLE, or back-to-back at the end of a word's second stop bit.
  assign w_pop       = w_fifo_ne &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_baud_end && r_byte_sel));
  assign w_count_nxt = r_count + CW'(w_commit) - CW'(w_pop);

  // The slot at wr_ptr is never the one being popped, so slices land straight in the array.
  always_ff @(posedge i_top_gck) begin
    if (w_wr_cap) begin
      r_mem[r_wr_ptr][{i_utx_ctr, 2'b00} +: 4] <= i_utx_slice;
    end
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_wr_act <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (i_utx_ctr == 2'd0) begin
        r_wr_act <= w_wr_acc;
      end else if (w_commit) begin
        r_wr_act <= 1'b0;
      end
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
    end
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte_sel <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift    <= r_mem[r_rd_ptr];
            r_byte_sel <= 1'b0;
            r_bit      <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (!r_byte_sel) begin
              r_byte_sel <= 1'b1;
              r_tx       <= 1'b0;
              r_state    <= START;
            end else if (w_pop) begin
              r_shift    <= r_mem[r_rd_ptr];
              r_byte_sel <= 1'b0;
              r_bit      <= '0;
              r_tx       <= 1'b0;
              r_state    <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_utx_tx   = r_tx;
  assign o_utx_full = r_full;
  assign o_utx_busy = (r_state != IDLE) || w_fifo_ne;

endmodule

// File: tb/tb_idli_uart_tx_m.sv
// Bench for idli_uart_tx_m: queue-level reference model compared every cycle, a line receiver, and directed scenarios.
module tb_idli_uart_tx_m;

  localparam int CPB   = 4;
  localparam int DEPTH = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ctr   = 2'd0;
  logic       wr_en = 1'b0;
  logic [3:0] slice = 4'd0;
  logic       full;
  logic       busy;
  logic       tx;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit ctr_hold = 1'b0;

  always #5 clk = ~clk;

  idli_uart_tx_m #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .i_top_gck   (clk),
    .i_top_rst_n (rst_n),
    .i_utx_ctr   (ctr),
    .i_utx_wr_en (wr_en),
    .i_utx_slice (slice),
    .o_utx_full  (full),
    .o_utx_busy  (busy),
    .o_utx_tx    (tx)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Free-running core slice counter; ctr_hold stretches one value to shift its phase.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (ctr_hold) ctr_hold = 1'b0;
      else          ctr = ctr + 2'd1;
    end
  end

  // Reference model: words waiting in the FIFO, and the line samples still to be sent.
  logic [15:0] m_wq[$];
  bit          m_sq[$];
  bit          m_act;
  logic [15:0] m_word;
  logic [15:0] m_w;
  logic [7:0]  m_b;
  bit          m_drop;
  int          m_sz0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wq.delete();
      m_sq.delete();
      m_act  = 1'b0;
      m_word = '0;
    end else begin
      m_sz0 = m_wq.size();
      if (m_sq.size() > 0) m_drop = m_sq.pop_front();
      if (m_sq.size() == 0 && m_wq.size() > 0) begin
        m_w = m_wq.pop_front();
        for (int b = 0; b < 2; b++) begin
          m_b = m_w[8*b +: 8];
          repeat (CPB) m_sq.push_back(1'b0);
          for (int i = 0; i < 8; i++) repeat (CPB) m_sq.push_back(m_b[i]);
          repeat (CPB) m_sq.push_back(1'b1);
        end
      end
      if (ctr == 2'd0) begin
        m_act = wr_en && (m_sz0 < DEPTH);
        if (m_act) m_word[3:0] = slice;
      end else if (m_act) begin
        m_word[4*ctr +: 4] = slice;
        if (ctr == 2'd3) begin
          m_wq.push_back(m_word);
          m_act = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tx",   32'(tx),   (m_sq.size() > 0) ? 32'(m_sq[0]) : 32'd1);
      chk("busy", 32'(busy), 32'((m_sq.size() > 0) || (m_wq.size() > 0)));
      chk("full", 32'(full), 32'(m_wq.size() == DEPTH));
    end
  end

  // Line receiver: samples mid-bit, discards any byte interrupted by reset.
  logic [7:0] rxq[$];
  initial begin : rx
    logic [7:0] rb;
    bit         bad;
    logic       s;
    rb = '0;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        bad = 1'b0;
        repeat (CPB/2) begin @(negedge clk); if (!rst_n) bad = 1'b1; end
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (!rst_n) bad = 1'b1; end
          rb[i] = tx;
        end
        repeat (CPB) begin @(negedge clk); if (!rst_n) bad = 1'b1; end
        s = tx;
        if (!bad) begin
          chk("rx_stop", 32'(s), 32'd1);
          rxq.push_back(rb);
        end
      end
    end
  end

  task automatic check_rx(input string nm, input logic [47:0] ex, input int n);
    chk({nm, "_nbytes"}, rxq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rxq.size()) chk({nm, "_byte"}, 32'(rxq[i]), 32'(ex[47-8*i -: 8]));
    end
    rxq.delete();
  endtask

  task automatic wait_ctr(input logic [1:0] v);
    int n = 0;
    while (ctr != v && n < 8) begin @(posedge clk); #2; n++; end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #2; end
  endtask

  task automatic write_word(input logic [15:0] w, output int e);
    wait_ctr(2'd0);
    chk("wr_align", 32'(ctr), 32'd0);
    wr_en = 1'b1;
    slice = w[3:0];
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #2;
      slice = w[4*k +: 4];
    end
    @(posedge clk); #2;
    wr_en = 1'b0;
    slice = 4'd0;
    e = cyc;
  endtask

  task automatic wait_tx_low(output int at);
    int n = 0;
    at = -1;
    while (n < 300) begin
      @(posedge clk); #2; n++;
      if (tx === 1'b0) begin at = cyc; break; end
    end
  endtask

  task automatic wait_idle(output int at);
    int n = 0;
    at = -1;
    while (n < 1000) begin
      @(posedge clk); #2; n++;
      if (busy === 1'b0) begin at = cyc; break; end
    end
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #2;
  endtask

  initial begin
    int e;
    int t;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx",   32'(tx),   32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;

    // Single word
    write_word(16'hA55A, e);
    wait_tx_low(t);
    chk("single_fall", t, e + 1);
    wait_idle(t);
    chk("single_busy_fall", t, e + 81);
    settle();
    check_rx("single", 48'h5AA5_0000_0000, 2);

    // Back-pressure: fourth word meets a full FIFO
    write_word(16'h1111, e);
    write_word(16'h2222, t);
    write_word(16'h3333, t);
    chk("bp_full", 32'(full), 32'd1);
    write_word(16'h4444, t);
    wait_idle(t);
    chk("bp_end", t, e + 241);
    settle();
    check_rx("bp", 48'h1111_2222_3333, 6);

    // Misaligned write requests
    wait_ctr(2'd1);
    wr_en = 1'b1;
    @(posedge clk); #2;
    wr_en = 1'b0;
    wait_ctr(2'd2);
    wr_en = 1'b1;
    @(posedge clk); #2;
    wr_en = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("mis_busy", 32'(busy), 32'd0);
    chk("mis_tx",   32'(tx),   32'd1);
    chk("mis_rx",   rxq.size(), 0);

    // Commit and pop on the same edge (counter phase shifted by one cycle)
    write_word(16'h0102, e);
    write_word(16'h0304, t);
    ctr_hold = 1'b1;
    wait_cyc(e + 77);
    write_word(16'h0506, t);
    chk("pp_commit_edge", t, e + 81);
    chk("pp_full", 32'(full), 32'd0);
    chk("pp_busy", 32'(busy), 32'd1);
    wait_idle(t);
    chk("pp_end", t, e + 241);
    settle();
    check_rx("pp", 48'h0201_0403_0605, 6);

    // Reset during the data bits
    write_word(16'h00FF, e);
    wait_cyc(e + 11);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_tx",   32'(tx),   32'd1);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_full", 32'(full), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #2;
    chk("mr_after_tx",   32'(tx),   32'd1);
    chk("mr_after_busy", 32'(busy), 32'd0);
    chk("mr_after_rx",   rxq.size(), 0);
    write_word(16'h1234, e);
    wait_tx_low(t);
    chk("mr_fall", t, e + 1);
    wait_idle(t);
    settle();
    check_rx("mr", 48'h3412_0000_0000, 2);

    // Data extremes
    write_word(16'h0000, e);
    write_word(16'hFFFF, t);
    wait_idle(t);
    chk("ext_end", t, e + 161);
    settle();
    check_rx("ext", 48'h0000_FFFF_0000, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
